ahci_dma_fis_packer: RTL and testbench



---
 rtl/ahci_dma_fis_packer_pkg.sv | 20 ++
 rtl/ahci_fis_out_reg.sv | 54 +++++
 rtl/ahci_dma_fis_packer.sv | 176 +++++++++++++++++
 tb/tb_ahci_dma_fis_packer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahci_dma_fis_packer_pkg.sv
// Shared definitions for the AHCI Data FIS packer: FIS type code, FSM states, header builder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ahci_pkg;

    localparam logic [7:0] FIS_TYPE_DATA = 8'h46;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HDR      = 2'd1,
        ST_DATA     = 2'd2,
        ST_WAIT_ACK = 2'd3
    } fis_state_t;

    // Data FIS header dword: PM port in [11:8], FIS type in [7:0], rest reserved zero.
    function automatic logic [31:0] build_data_hdr(input logic [3:0] pm);
        return {20'h0, pm, FIS_TYPE_DATA};
    endfunction

endpackage

// File: rtl/ahci_fis_out_reg.sv
// One-entry output register carrying a FIS dword plus first/last flags to the link.
// Latency: 1 cycle from load to o_vld.
// Backpressure: holds contents stable while i_rdy is low; can reload in the cycle it is drained.
module ahci_fis_out_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [31:0] i_dat,
    input  logic        i_first,
    input  logic        i_last,
    input  logic        i_rdy,
    output logic        o_can_load,
    output logic        o_vld,
    output logic [31:0] o_dat,
    output logic        o_first,
    output logic        o_last
);

    logic        r_vld;
    logic [31:0] r_dat;
    logic        r_first;
    logic        r_last;

    assign o_can_load = !r_vld || i_rdy;
    assign o_vld      = r_vld;
    assign o_dat      = r_dat;
    assign o_first    = r_first;
    assign o_last     = r_last;

    // Load a new dword, or drop valid (and flags) once the held dword is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= 1'b0;
            r_dat   <= 32'h0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_clr) begin
            r_vld   <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_vld   <= 1'b1;
            r_dat   <= i_dat;
            r_first <= i_first;
            r_last  <= i_last;
        end else if (i_rdy) begin
            r_vld   <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/ahci_dma_fis_packer.sv
// Packs DMA read FIFO dwords into Data FISes (header + up to MAX_FIS_DWORDS payload), ack-gated.
// Latency: header 1 cycle after start/ack; FIFO word to fis_data 1 cycle; 1 dword/cycle sustained.
// Backpressure: fis_ready low holds the output register and stops FIFO pops. Option: AHCI_FIS_PACKER_STATS_EN.
module ahci_dma_fis_packer
    import ahci_pkg::*;
#(
    parameter int WCNT_BITS      = 21,
    parameter int MAX_FIS_DWORDS = 2048
) (
    input  logic                 mclk,
    input  logic                 mrst,
    input  logic                 xfer_start,
    input  logic [WCNT_BITS-1:0] xfer_dwords,
    input  logic [3:0]           pm_port,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    input  logic [31:0]          fifo_dout,
    input  logic                 fifo_dout_av,
    output logic                 fifo_dout_re,
    output logic [31:0]          fis_data,
    output logic                 fis_valid,
    output logic                 fis_first,
    output logic                 fis_last,
    input  logic                 fis_ready,
    input  logic                 fis_ack,
    input  logic                 fis_err
`ifdef AHCI_FIS_PACKER_STATS_EN
   ,output logic [31:0]          stat_dwords,
    output logic [15:0]          stat_fises
`endif
);

    localparam int FCW = $clog2(MAX_FIS_DWORDS) + 1;

    fis_state_t           r_state;
    logic [WCNT_BITS-1:0] r_remaining;
    logic [FCW-1:0]       r_fis_cnt;
    logic [3:0]           r_pm_port;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic                 w_can_load;
    logic                 w_accept;
    logic                 w_abort;
    logic                 w_pop;
    logic                 w_hdr_load;
    logic [WCNT_BITS-1:0] w_len_src;
    logic [FCW-1:0]       w_fis_len;
    logic [3:0]           w_hdr_pm;

    assign w_accept = fis_valid && fis_ready;
    assign w_abort  = fis_err && (r_state != ST_IDLE);

    // Payload may start popping in the header cycle as the header leaves, so FISes stream gap-free.
    assign w_pop = ((r_state == ST_DATA) || (r_state == ST_HDR)) && fifo_dout_av &&
                   w_can_load && (r_fis_cnt != '0) && !fis_err;

    assign w_hdr_load = ((r_state == ST_IDLE) && xfer_start && (xfer_dwords != '0)) ||
                        ((r_state == ST_WAIT_ACK) && fis_ack && !fis_err && (r_remaining != '0));

    // Length of the next FIS comes from the fresh request when idle, else from what is left.
    always_comb begin
        w_len_src = (r_state == ST_IDLE) ? xfer_dwords : r_remaining;
        w_hdr_pm  = (r_state == ST_IDLE) ? pm_port : r_pm_port;
        if (w_len_src >= WCNT_BITS'(MAX_FIS_DWORDS))
            w_fis_len = FCW'(MAX_FIS_DWORDS);
        else
            w_fis_len = FCW'(w_len_src);
    end

    assign fifo_dout_re = w_pop;
    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;

    ahci_fis_out_reg u_out_reg (
        .clk        (mclk),
        .rst        (mrst),
        .i_clr      (w_abort),
        .i_load     (w_hdr_load || w_pop),
        .i_dat      (w_hdr_load ? build_data_hdr(w_hdr_pm) : fifo_dout),
        .i_first    (w_hdr_load),
        .i_last     (!w_hdr_load && (r_fis_cnt == FCW'(1))),
        .i_rdy      (fis_ready),
        .o_can_load (w_can_load),
        .o_vld      (fis_valid),
        .o_dat      (fis_data),
        .o_first    (fis_first),
        .o_last     (fis_last)
    );

    // Transfer sequencing: header, payload, wait for link ack; fis_err aborts from any active state.
    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_fis_cnt   <= '0;
            r_pm_port   <= 4'h0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (w_pop) begin
                r_remaining <= r_remaining - 1'b1;
                r_fis_cnt   <= r_fis_cnt - 1'b1;
            end
            if (w_abort) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_error <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (xfer_start) begin
                            r_remaining <= xfer_dwords;
                            r_pm_port   <= pm_port;
                            if (xfer_dwords == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state   <= ST_HDR;
                                r_busy    <= 1'b1;
                                r_fis_cnt <= w_fis_len;
                            end
                        end
                    end
                    ST_HDR: begin
                        if (w_accept) r_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (w_accept && fis_last) r_state <= ST_WAIT_ACK;
                    end
                    ST_WAIT_ACK: begin
                        if (fis_ack) begin
                            if (r_remaining != '0) begin
                                r_state   <= ST_HDR;
                                r_fis_cnt <= w_fis_len;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef AHCI_FIS_PACKER_STATS_EN
    logic [31:0] r_stat_dwords;
    logic [15:0] r_stat_fises;

    assign stat_dwords = r_stat_dwords;
    assign stat_fises  = r_stat_fises;

    // Count payload dwords taken by the link and FISes it acknowledged.
    always_ff @(posedge mclk or posedge mrst) begin
        if (mrst) begin
            r_stat_dwords <= 32'h0;
            r_stat_fises  <= 16'h0;
        end else begin
            if (w_accept && !fis_first)
                r_stat_dwords <= r_stat_dwords + 32'd1;
            if ((r_state == ST_WAIT_ACK) && fis_ack && !fis_err)
                r_stat_fises <= r_stat_fises + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ahci_dma_fis_packer.sv
// Bench for ahci_dma_fis_packer: FIFO and link models, expected-dword queue, per-cycle checks.
// Latency: n/a.
// Backpressure: exercises fis_ready toggling and FIFO starvation.
module tb_ahci_dma_fis_packer;

    localparam int WB   = 21;
    localparam int MAXF = 2048;

    typedef struct {
        logic [31:0] data;
        logic        first;
        logic        last;
    } exp_t;

    logic          mclk = 1'b0;
    logic          mrst = 1'b1;
    logic          xfer_start = 1'b0;
    logic [WB-1:0] xfer_dwords = '0;
    logic [3:0]    pm_port = 4'h0;
    logic          busy, done, error;
    logic [31:0]   fifo_dout;
    logic          fifo_dout_av;
    logic          fifo_dout_re;
    logic [31:0]   fis_data;
    logic          fis_valid, fis_first, fis_last;
    logic          fis_ready;
    logic          fis_ack = 1'b0;
    logic          fis_err = 1'b0;
`ifdef AHCI_FIS_PACKER_STATS_EN
    logic [31:0]   stat_dwords;
    logic [15:0]   stat_fises;
`endif

    // FIFO model: word k popped since time zero is 0xA0000000 + k.
    int  pop_total = 0;
    int  fifo_top  = 0;
    bit  av_en     = 1'b1;
    bit  rdy_tog   = 1'b0;
    int  cyc       = 0;

    assign fifo_dout    = 32'hA000_0000 + 32'(pop_total);
    assign fifo_dout_av = av_en && (pop_total < fifo_top);
    assign fis_ready    = !rdy_tog || cyc[0];

    always #5 mclk = ~mclk;

    ahci_dma_fis_packer #(.WCNT_BITS(WB), .MAX_FIS_DWORDS(MAXF)) dut (
        .mclk(mclk), .mrst(mrst), .xfer_start(xfer_start), .xfer_dwords(xfer_dwords),
        .pm_port(pm_port), .busy(busy), .done(done), .error(error),
        .fifo_dout(fifo_dout), .fifo_dout_av(fifo_dout_av), .fifo_dout_re(fifo_dout_re),
        .fis_data(fis_data), .fis_valid(fis_valid), .fis_first(fis_first), .fis_last(fis_last),
        .fis_ready(fis_ready), .fis_ack(fis_ack), .fis_err(fis_err)
`ifdef AHCI_FIS_PACKER_STATS_EN
       ,.stat_dwords(stat_dwords), .stat_fises(stat_fises)
`endif
    );

    always @(posedge mclk) begin
        cyc <= cyc + 1;
        if (fifo_dout_re && fifo_dout_av) pop_total <= pop_total + 1;
    end

    int   vecs = 0;
    int   errs = 0;
    exp_t exp_q[$];
    int   lasts_seen = 0;
    int   hdrs_seen  = 0;
    int   done_seen  = 0;
    logic last_err   = 1'b0;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        vecs++;
        errs++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Compare process: every accepted dword against the model, hold-under-stall, done rules.
    bit          prev_stall = 1'b0;
    bit          prev_done  = 1'b0;
    logic [31:0] pd;
    logic        pf, pl;
    always @(negedge mclk) begin
        if (mrst) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {fis_valid, fis_first, fis_last, fis_data}, {1'b1, pf, pl, pd});
            if (fis_valid && fis_ready) begin
                if (exp_q.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_dword: got %h required none", fis_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("fis_dword", {fis_first, fis_last, fis_data}, {e.first, e.last, e.data});
                end
                if (fis_first) hdrs_seen++;
                if (fis_last)  lasts_seen++;
                chk("busy_during_fis", busy, 1);
            end
            if (fifo_dout_re) chk("pop_only_when_avail", fifo_dout_av, 1);
            if (done) begin
                chk("busy_low_at_done", busy, 0);
                chk("done_single_cycle", prev_done, 0);
                done_seen++;
                last_err = error;
            end
            prev_done  = done;
            prev_stall = fis_valid && !fis_ready;
            pd = fis_data;
            pf = fis_first;
            pl = fis_last;
        end
    end

    // Model: one FIS is its header followed by min(left, MAXF) consecutive FIFO words.
    task automatic push_fis(input logic [3:0] p, inout int next_word, inout int left);
        int   chunk;
        exp_t e;
        chunk = (left > MAXF) ? MAXF : left;
        e.data = {20'h0, p, 8'h46}; e.first = 1'b1; e.last = 1'b0;
        exp_q.push_back(e);
        for (int k = 0; k < chunk; k++) begin
            e.data  = 32'hA000_0000 + 32'(next_word + k);
            e.first = 1'b0;
            e.last  = (k == chunk - 1);
            exp_q.push_back(e);
        end
        next_word += chunk;
        left      -= chunk;
    endtask

    task automatic pulse(input bit is_err);
        @(posedge mclk); #1;
        if (is_err) fis_err = 1'b1; else fis_ack = 1'b1;
        @(posedge mclk); #1;
        fis_err = 1'b0;
        fis_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {busy, done, error, fis_valid, fis_first, fis_last, fifo_dout_re, fis_data}, 40'h0);
    endtask

    // Run one transfer; err_fis selects which FIS gets fis_err instead of fis_ack (-1: none).
    task automatic run_xfer(input int n, input logic [3:0] p, input int err_fis, input bit pin_hdr);
        int  base, next_word, left, lasts0, done0, f, budget;
        bit  exp_err;
        base = pop_total; next_word = pop_total; left = n;
        lasts0 = lasts_seen; done0 = done_seen; exp_err = 1'b0;
        fifo_top = pop_total + n + 8;
        if (n > 0) push_fis(p, next_word, left);
        @(posedge mclk); #1;
        xfer_start = 1'b1; xfer_dwords = WB'(n); pm_port = p;
        @(posedge mclk); #1;
        xfer_start = 1'b0;
        if (pin_hdr) chk("hdr_one_cycle_after_start", {fis_valid, fis_first, fis_data}, {2'b11, 32'h0000_0346});
        f = 0;
        while (n > 0) begin
            budget = 0;
            while (lasts_seen < lasts0 + f + 1 && budget < 6000) begin
                @(posedge mclk); budget++;
            end
            if (budget >= 6000) begin timeout_fail("last_dword_wait"); break; end
            repeat (3) @(posedge mclk);
            if (f == err_fis) begin
                exp_err = 1'b1;
                pulse(1'b1);
                break;
            end
            if (left > 0) push_fis(p, next_word, left);
            pulse(1'b0);
            if (next_word - base == n && exp_q.size() == 0) break;
            f++;
        end
        budget = 0;
        while (done_seen == done0 && budget < 50) begin
            @(posedge mclk); budget++;
        end
        if (budget >= 50) timeout_fail("done_wait");
        repeat (20) @(posedge mclk);
        #1;
        chk("done_count", 40'(done_seen - done0), 40'd1);
        chk("error_flag", last_err, exp_err);
        chk("pop_count", 40'(pop_total - base), 40'(next_word - base));
        chk("all_dwords_seen", 40'(exp_q.size()), 40'd0);
        chk("busy_idle_after", busy, 0);
    endtask

    initial begin
        int h0, p0, budget;
        repeat (3) @(posedge mclk);
        #1;
        check_reset_outputs("reset_outputs");
        mrst = 1'b0;

        // Single short FIS with the header pinned literally.
        p0 = pop_total; h0 = hdrs_seen;
        run_xfer(5, 4'h3, -1, 1'b1);
        chk("five_word_pops", 40'(pop_total - p0), 40'd5);

        // Split into 2048 + 2048 + 4.
        p0 = pop_total; h0 = hdrs_seen;
        run_xfer(4100, 4'hA, -1, 1'b0);
        chk("split_pops_4100", 40'(pop_total - p0), 40'd4100);
        chk("split_headers_3", 40'(hdrs_seen - h0), 40'd3);

        // Zero-length: done with no error one cycle after start, nothing on the link.
        h0 = hdrs_seen;
        @(posedge mclk); #1;
        xfer_start = 1'b1; xfer_dwords = '0; pm_port = 4'h1;
        @(posedge mclk); #1;
        xfer_start = 1'b0;
        chk("zero_len_done", {busy, done, error}, 3'b010);
        repeat (5) @(posedge mclk);
        #1;
        chk("zero_len_no_header", 40'(hdrs_seen - h0), 40'd0);

        // FIFO starved for 10 cycles mid-FIS while fis_ready toggles.
        rdy_tog = 1'b1;
        fork
            run_xfer(20, 4'h5, -1, 1'b0);
            begin
                p0 = pop_total;
                budget = 0;
                while (pop_total - p0 < 5 && budget < 200) begin
                    @(posedge mclk); budget++;
                end
                if (budget >= 200) timeout_fail("gap_start_wait");
                #1 av_en = 1'b0;
                repeat (10) @(posedge mclk);
                #1 av_en = 1'b1;
            end
        join
        rdy_tog = 1'b0;

        // fis_err after the first of two FISes: error done, no second header.
        h0 = hdrs_seen;
        run_xfer(2050, 4'h7, 0, 1'b0);
        chk("err_single_header", 40'(hdrs_seen - h0), 40'd1);

        // Reset in the middle of payload, then a normal 2-dword transfer.
        begin
            int nw, lf;
            nw = pop_total; lf = 10;
            p0 = pop_total;
            fifo_top = pop_total + 20;
            push_fis(4'h2, nw, lf);
            @(posedge mclk); #1;
            xfer_start = 1'b1; xfer_dwords = WB'(10); pm_port = 4'h2;
            @(posedge mclk); #1;
            xfer_start = 1'b0;
            budget = 0;
            while (pop_total - p0 < 3 && budget < 100) begin
                @(posedge mclk); budget++;
            end
            if (budget >= 100) timeout_fail("mid_data_wait");
            #1 mrst = 1'b1;
            #1 check_reset_outputs("reset_mid_data");
            @(posedge mclk); #1;
            check_reset_outputs("reset_held");
            exp_q.delete();
            mrst = 1'b0;
        end
        run_xfer(2, 4'h9, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "global timeout");
    end

endmodule
